// File: rtl/cp0_irq_cause.sv
// CP0 Cause register with hardware interrupt synchronisers, sticky edge capture,
// software interrupt bits, exception code/BD capture and a registered interrupt request.
module cp0_irq_cause #(
    parameter int unsigned     NUM_HW_IRQ  = 6,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [5:0]      EDGE_MASK   = 6'b000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    input  logic [7:0]            im,
    input  logic                  ie,
    input  logic                  exl,
    input  logic                  cause_we,
    input  logic [31:0]           din,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    output logic [31:0]           dout,
    output logic                  int_req,
    output logic [2:0]            int_line
);

    localparam logic [5:0] IMPL_MASK = 6'((7'd1 << NUM_HW_IRQ) - 7'd1);
    localparam logic [5:0] EDGE_IMPL = EDGE_MASK & IMPL_MASK;
    localparam logic [5:0] LVL_IMPL  = ~EDGE_MASK & IMPL_MASK;

    logic [SYNC_STAGES-1:0][NUM_HW_IRQ-1:0] sync_q, sync_d;
    logic [5:0] s_prev_q, s_prev_d;
    logic [5:0] ip_edge_q, ip_edge_d;
    logic [1:0] sw_q, sw_d;
    logic       bd_q, bd_d;
    logic [4:0] exc_code_q, exc_code_d;
    logic       int_req_q, int_req_d;
    logic [2:0] int_line_q, int_line_d;

    logic [5:0] s6;
    logic [5:0] rise;
    logic [5:0] edge_clr;
    logic [5:0] ip_hw;
    logic [7:0] ip;
    logic [7:0] pend;
    logic       unused_din;

    assign unused_din = ^{din[31:16], din[7:0]};

    always_comb begin
        sync_d[0] = hw_irq;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Synchronised lines widened to six bits; unimplemented lines stay zero.
    always_comb begin
        s6 = '0;
        s6[NUM_HW_IRQ-1:0] = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        rise      = s6 & ~s_prev_q & EDGE_IMPL;
        edge_clr  = cause_we ? ~din[15:10] : '0;
        s_prev_d  = s6 & EDGE_IMPL;
        // A new edge wins over a simultaneous software clear.
        ip_edge_d = ((ip_edge_q & ~edge_clr) | rise) & EDGE_IMPL;
        ip_hw     = (s6 & LVL_IMPL) | ip_edge_q;
        ip        = {ip_hw, sw_q};
        pend      = ip & im;
    end

    always_comb begin
        sw_d       = cause_we ? din[9:8] : sw_q;
        exc_code_d = exc_req ? exc_code : exc_code_q;
        bd_d       = (exc_req && !exl) ? exc_bd : bd_q;
    end

    always_comb begin
        int_req_d  = ie & ~exl & (|pend);
        int_line_d = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (pend[k]) begin
                int_line_d = k[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            s_prev_q   <= '0;
            ip_edge_q  <= '0;
            sw_q       <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '1;
            int_req_q  <= 1'b0;
            int_line_q <= '0;
        end else begin
            sync_q     <= sync_d;
            s_prev_q   <= s_prev_d;
            ip_edge_q  <= ip_edge_d;
            sw_q       <= sw_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            int_req_q  <= int_req_d;
            int_line_q <= int_line_d;
        end
    end

    assign dout     = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign int_req  = int_req_q;
    assign int_line = int_line_q;

endmodule

// File: tb/tb_cp0_irq_cause.sv
// Directed bench for cp0_irq_cause: a full-width instance with line 0 edge-triggered
// and a narrow single-stage instance sharing the same control inputs.
module tb_cp0_irq_cause;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_irq;
    logic [7:0]  im;
    logic        ie;
    logic        exl;
    logic        cause_we;
    logic [31:0] din;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] dout;
    logic        int_req;
    logic [2:0]  int_line;
    logic [31:0] dout2;
    logic        int_req2;
    logic [2:0]  int_line2;

    int tests;
    int fails;

    cp0_irq_cause #(
        .NUM_HW_IRQ (6),
        .SYNC_STAGES(2),
        .EDGE_MASK  (6'b000001)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .hw_irq  (hw_irq),
        .im      (im),
        .ie      (ie),
        .exl     (exl),
        .cause_we(cause_we),
        .din     (din),
        .exc_req (exc_req),
        .exc_code(exc_code),
        .exc_bd  (exc_bd),
        .dout    (dout),
        .int_req (int_req),
        .int_line(int_line)
    );

    // Three lines, single stage; EDGE_MASK bit 3 names an unimplemented line.
    cp0_irq_cause #(
        .NUM_HW_IRQ (3),
        .SYNC_STAGES(1),
        .EDGE_MASK  (6'b001000)
    ) u_narrow (
        .clk     (clk),
        .reset   (reset),
        .hw_irq  (hw_irq[2:0]),
        .im      (im),
        .ie      (ie),
        .exl     (exl),
        .cause_we(cause_we),
        .din     (din),
        .exc_req (exc_req),
        .exc_code(exc_code),
        .exc_bd  (exc_bd),
        .dout    (dout2),
        .int_req (int_req2),
        .int_line(int_line2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        hw_irq   = '0;
        im       = '0;
        ie       = 1'b0;
        exl      = 1'b0;
        cause_we = 1'b0;
        din      = '0;
        exc_req  = 1'b0;
        exc_code = '0;
        exc_bd   = 1'b0;
        step();
        step();
        tests++;
        if (dout !== 32'h0000007C) begin
            fails++; $display("FAIL reset_held_dout: got %h expected %h", dout, 32'h0000007C);
        end
        reset = 1'b1;
        step();
        tests++;
        if (dout !== 32'h0000007C) begin
            fails++; $display("FAIL reset_dout: got %h expected %h", dout, 32'h0000007C);
        end
        tests++;
        if (int_req !== 1'b0 || int_line !== 3'd0) begin
            fails++; $display("FAIL reset_int: got %b/%0d expected 0/0", int_req, int_line);
        end
    endtask

    task automatic test_level();
        im = 8'h10; ie = 1'b1; exl = 1'b0;
        hw_irq = 6'b000100;
        step();
        tests++;
        if (dout[12] !== 1'b0) begin
            fails++; $display("FAIL level_ip_early: got %b expected 0", dout[12]);
        end
        step();
        tests++;
        if (dout[12] !== 1'b1 || int_req !== 1'b0) begin
            fails++; $display("FAIL level_ip_2cyc: got ip=%b req=%b expected ip=1 req=0", dout[12], int_req);
        end
        step();
        tests++;
        if (int_req !== 1'b1 || int_line !== 3'd4) begin
            fails++; $display("FAIL level_req_3cyc: got %b/%0d expected 1/4", int_req, int_line);
        end
        hw_irq = '0;
        step();
        step();
        tests++;
        if (dout[12] !== 1'b0 || int_req !== 1'b1) begin
            fails++; $display("FAIL level_fall_2cyc: got ip=%b req=%b expected ip=0 req=1", dout[12], int_req);
        end
        step();
        tests++;
        if (int_req !== 1'b0 || int_line !== 3'd0) begin
            fails++; $display("FAIL level_fall_3cyc: got %b/%0d expected 0/0", int_req, int_line);
        end
    endtask

    task automatic test_edge();
        im = 8'h04; ie = 1'b1; exl = 1'b0;
        hw_irq[0] = 1'b1;
        step();
        hw_irq[0] = 1'b0;
        step();
        step();
        tests++;
        if (dout[10] !== 1'b1) begin
            fails++; $display("FAIL edge_set: got %b expected 1", dout[10]);
        end
        step();
        step();
        step();
        tests++;
        if (dout[10] !== 1'b1 || int_req !== 1'b1 || int_line !== 3'd2) begin
            fails++; $display("FAIL edge_sticky: got ip=%b req=%b line=%0d expected 1/1/2", dout[10], int_req, int_line);
        end
        cause_we = 1'b1; din = 32'h0;
        step();
        cause_we = 1'b0;
        tests++;
        if (dout[10] !== 1'b0) begin
            fails++; $display("FAIL edge_clear: got %b expected 0", dout[10]);
        end
        hw_irq[0] = 1'b1;
        step();
        hw_irq[0] = 1'b0;
        step();
        cause_we = 1'b1; din = 32'h0;
        step();
        cause_we = 1'b0;
        tests++;
        if (dout[10] !== 1'b1) begin
            fails++; $display("FAIL edge_set_wins: got %b expected 1", dout[10]);
        end
        cause_we = 1'b1; din = 32'h0;
        step();
        cause_we = 1'b0;
        im = '0;
        step();
        step();
    endtask

    task automatic test_sw_irq();
        cause_we = 1'b1; din = 32'hFFFFFFFF;
        step();
        cause_we = 1'b0; din = '0;
        tests++;
        if (dout !== 32'h0000037C) begin
            fails++; $display("FAIL sw_write_dout: got %h expected %h", dout, 32'h0000037C);
        end
        im = 8'h02; ie = 1'b1; exl = 1'b0;
        step();
        tests++;
        if (int_req !== 1'b1 || int_line !== 3'd1) begin
            fails++; $display("FAIL sw_req: got %b/%0d expected 1/1", int_req, int_line);
        end
        exl = 1'b1;
        step();
        tests++;
        if (int_req !== 1'b0) begin
            fails++; $display("FAIL exl_drop: got %b expected 0", int_req);
        end
        exl = 1'b0;
        step();
        tests++;
        if (int_req !== 1'b1) begin
            fails++; $display("FAIL exl_restore: got %b expected 1", int_req);
        end
        ie = 1'b0;
        step();
        tests++;
        if (int_req !== 1'b0) begin
            fails++; $display("FAIL ie_drop: got %b expected 0", int_req);
        end
        cause_we = 1'b1; din = '0;
        step();
        cause_we = 1'b0;
        im = '0;
    endtask

    task automatic test_exc();
        exc_req = 1'b1; exc_code = 5'd8; exc_bd = 1'b1; exl = 1'b0;
        step();
        tests++;
        if (dout !== 32'h80000020) begin
            fails++; $display("FAIL exc_bd_load: got %h expected %h", dout, 32'h80000020);
        end
        exc_code = 5'd12; exc_bd = 1'b0; exl = 1'b1;
        step();
        tests++;
        if (dout !== 32'h80000030) begin
            fails++; $display("FAIL exc_bd_hold: got %h expected %h", dout, 32'h80000030);
        end
        exc_code = 5'd0; exc_bd = 1'b0; exl = 1'b0;
        cause_we = 1'b1; din = 32'h00000300;
        step();
        exc_req = 1'b0; cause_we = 1'b0; din = '0;
        tests++;
        if (dout !== 32'h00000300) begin
            fails++; $display("FAIL exc_and_mtc0: got %h expected %h", dout, 32'h00000300);
        end
        step();
        tests++;
        if (dout !== 32'h00000300) begin
            fails++; $display("FAIL exc_idle_hold: got %h expected %h", dout, 32'h00000300);
        end
        cause_we = 1'b1; din = '0;
        step();
        cause_we = 1'b0;
    endtask

    task automatic test_narrow();
        hw_irq = 6'h3F; im = 8'hFF; ie = 1'b1; exl = 1'b0;
        step();
        tests++;
        if (dout2[15:8] !== 8'h1C || int_req2 !== 1'b0) begin
            fails++; $display("FAIL narrow_ip_1cyc: got ip=%h req=%b expected ip=1c req=0", dout2[15:8], int_req2);
        end
        step();
        tests++;
        if (int_req2 !== 1'b1 || int_line2 !== 3'd4) begin
            fails++; $display("FAIL narrow_req: got %b/%0d expected 1/4", int_req2, int_line2);
        end
        cause_we = 1'b1; din = 32'hFFFFFFFF;
        step();
        cause_we = 1'b0; din = '0;
        tests++;
        if (dout2[15:8] !== 8'h1F) begin
            fails++; $display("FAIL narrow_unimpl: got %h expected %h", dout2[15:8], 8'h1F);
        end
        step();
        step();
        tests++;
        if (dout[15:8] !== 8'hFF || int_req !== 1'b1 || int_line !== 3'd7) begin
            fails++; $display("FAIL all_pending: got ip=%h req=%b line=%0d expected ff/1/7", dout[15:8], int_req, int_line);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (dout !== 32'h0000007C || int_req !== 1'b0 || int_line !== 3'd0) begin
            fails++; $display("FAIL async_reset: got %h/%b/%0d expected 0000007c/0/0", dout, int_req, int_line);
        end
        hw_irq = '0;
        step();
        #3;
        reset = 1'b1;
        step();
        step();
        step();
        step();
        tests++;
        if (dout !== 32'h0000007C || int_req !== 1'b0) begin
            fails++; $display("FAIL reset_release_clean: got %h/%b expected 0000007c/0", dout, int_req);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_level();
        test_edge();
        test_sw_irq();
        test_exc();
        test_narrow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
